ahbmtx_l2_in_stg: RTL and testbench
===================================

Name: ahbmtx_l2_in_stg

Overview:
- Input stage of the L2 AHB bus matrix, one instance per master-side port.
- Sits directly upstream of the per-slave output arbiter. Produces that arbiter's req_port and the address/control it selects.
- Absorbs an address phase into a holding register when the shared slave path is not immediately available, and stalls the master via HREADYOUTS until the transfer is granted and completes.
- Forwards the slave's data-phase ready and response back to the master.

Parameters:
ADDR_WIDTH, 32, width of HADDR in and out.

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HSELS  in  1  port select from master-side decode
HADDRS  in  ADDR_WIDTH  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write
HSIZES  in  3  master size
HBURSTS  in  3  master burst
HPROTS  in  4  master protection
HMASTLOCKS  in  1  master lock
HREADYS  in  1  master-side bus HREADY
HREADYOUTS  out  1  ready to master
HRESPS  out  1  response to master
grant  in  1  arbiter has selected this port (addr_in_port matches, no_port low)
HREADYM  in  1  ready from selected slave
HRESPM  in  1  response from selected slave
req_port  out  1  request to output arbiter
sel_out  out  1  HSEL toward output stage
HADDRO  out  ADDR_WIDTH  address toward output stage
HTRANSO  out  2  transfer toward output stage
HWRITEO  out  1  write toward output stage
HSIZEO  out  3  size toward output stage
HBURSTO  out  3  burst toward output stage
HPROTO  out  4  protection toward output stage
HMASTLOCKO  out  1  lock toward output stage

Behaviour:
- Clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values:
  - pend=0, data_ph=0, holding regs=0.
  - HREADYOUTS=1, HRESPS=0 (OKAY), req_port=0.
- new_tran = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ sampled).
- take = grant & HREADYM.
- Address mux: when pend=1, all *O outputs come from the holding regs. Otherwise they are driven live from the *S inputs.
- sel_out = pend | (HSELS & HREADYS).
- req_port = pend | new_tran, combinational.
- Holding register, per-field capture on new_tran & ~take:
  - Loads HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK and sets pend=1.
  - No load otherwise.
- pend clears on take. If a new_tran coincides with take while pend=1, that case cannot occur, because HREADYOUTS=0 while pend and the master is therefore stalled.
- data_ph (this port owns the slave data phase):
  - Next = 1 when take & HTRANSO[1].
  - Else 0 when HREADYM.
  - Else hold.
- HREADYOUTS:
  - data_ph=1: HREADYM.
  - Else pend=1: 0.
  - Else: 1.
- HRESPS = data_ph ? HRESPM : 0.
  - ERROR is forwarded on both cycles of the slave's two-cycle response.
  - IDLE/BUSY or unselected transfers get a zero-wait OKAY.
- Latency:
  - Granted live transfer: 0 added cycles.
  - Pending transfer: at least 1 stall cycle, plus every cycle grant=0.
- Simultaneous completion: when the previous data phase completes (HREADYM=1) in the same cycle a new address is sampled but not granted, HREADYOUTS=1 for the old transfer and the new address enters holding.
- Locked sequences: HMASTLOCKO from holding is kept until take. The arbiter keeps the grant.
- An async reset mid-transfer drops pend/data_ph immediately. The outputs take their reset values in the same cycle.

Test Plan:
- Reset, then NONSEQ write to 0x2000_0000 with grant=1, HREADYM=1 -> req_port=1, HADDRO=0x2000_0000 same cycle, pend stays 0, HREADYOUTS=1.
- NONSEQ read to 0x0000_0040 with grant=0 for 3 cycles, then grant=1 -> pend=1, HADDRO held at 0x40, HREADYOUTS=0 for 4 cycles, data_ph=1 after take.
- Slave inserts 2 wait states (HREADYM=0) in data phase -> HREADYOUTS mirrors 0,0,1; data_ph clears on the third cycle.
- Slave ERROR: HRESPM=1 with HREADYM=0 then HREADYM=1 -> HRESPS=1 on both cycles, HREADYOUTS 0 then 1.
- Back-to-back: data phase completes while the next NONSEQ to 0x104 is refused (grant=0) -> HREADYOUTS=1 that cycle, holding=0x104, pend=1 next cycle.
- Assert HRESETn=0 while pend=1 and data_ph=1 -> HREADYOUTS=1, HRESPS=0, req_port=0 immediately; after release the first new_tran is forwarded live.

Source files
------------

// File: rtl/ahbmtx_l2_in_stg.sv
// L2 AHB matrix input stage: holds a master's address phase until the
// output arbiter grants it, and returns slave ready/response to the master.
//
// Ports:
//   HCLK, HRESETn              clock, async active-low reset
//   HSELS..HMASTLOCKS, HREADYS master-side address/control and bus ready
//   HREADYOUTS, HRESPS         ready/response returned to the master
//   grant, HREADYM, HRESPM     arbiter grant, selected slave ready/response
//   req_port                   request to the output arbiter
//   sel_out, HADDRO..HMASTLOCKO  address/control toward the output stage
module ahbmtx_l2_in_stg #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    input  logic                  grant,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic                  req_port,
    output logic                  sel_out,
    output logic [ADDR_WIDTH-1:0] HADDRO,
    output logic [1:0]            HTRANSO,
    output logic                  HWRITEO,
    output logic [2:0]            HSIZEO,
    output logic [2:0]            HBURSTO,
    output logic [3:0]            HPROTO,
    output logic                  HMASTLOCKO
);

    logic                  pend_q, pend_d;
    logic                  data_ph_q, data_ph_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [3:0]            hprot_q, hprot_d;
    logic                  hlock_q, hlock_d;

    logic new_tran;
    logic take;
    logic load;

    assign new_tran = HSELS & HTRANSS[1] & HREADYS;
    assign take     = grant & HREADYM;
    // A refused address phase is parked; the master is stalled while parked,
    // so no new address can arrive before the parked one is taken.
    assign load     = new_tran & ~take;

    always_comb begin
        pend_d    = pend_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        hburst_d  = hburst_q;
        hprot_d   = hprot_q;
        hlock_d   = hlock_q;
        data_ph_d = data_ph_q;
        if (load) begin
            pend_d   = 1'b1;
            haddr_d  = HADDRS;
            htrans_d = HTRANSS;
            hwrite_d = HWRITES;
            hsize_d  = HSIZES;
            hburst_d = HBURSTS;
            hprot_d  = HPROTS;
            hlock_d  = HMASTLOCKS;
        end else if (take) begin
            pend_d   = 1'b0;
        end
        if (take && HTRANSO[1]) begin
            data_ph_d = 1'b1;
        end else if (HREADYM) begin
            data_ph_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q    <= 1'b0;
            data_ph_q <= 1'b0;
            haddr_q   <= '0;
            htrans_q  <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            hburst_q  <= '0;
            hprot_q   <= '0;
            hlock_q   <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            data_ph_q <= data_ph_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            hburst_q  <= hburst_d;
            hprot_q   <= hprot_d;
            hlock_q   <= hlock_d;
        end
    end

    assign HADDRO     = pend_q ? haddr_q  : HADDRS;
    assign HTRANSO    = pend_q ? htrans_q : HTRANSS;
    assign HWRITEO    = pend_q ? hwrite_q : HWRITES;
    assign HSIZEO     = pend_q ? hsize_q  : HSIZES;
    assign HBURSTO    = pend_q ? hburst_q : HBURSTS;
    assign HPROTO     = pend_q ? hprot_q  : HPROTS;
    assign HMASTLOCKO = pend_q ? hlock_q  : HMASTLOCKS;

    // Request/select are gated by reset so they read 0 the instant
    // reset asserts, even if the master is still driving a transfer.
    assign sel_out  = HRESETn & (pend_q | (HSELS & HREADYS));
    assign req_port = HRESETn & (pend_q | new_tran);

    assign HREADYOUTS = data_ph_q ? HREADYM : ~pend_q;
    assign HRESPS     = data_ph_q & HRESPM;

endmodule

// File: tb/tb_ahbmtx_l2_in_stg.sv
// Testbench for ahbmtx_l2_in_stg: directed vector table, reset corner
// sequence and randomized traffic against a transaction-level model.
module tb_ahbmtx_l2_in_stg;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        rdy;
        logic        grant;
        logic        hm;
        logic        respm;
        logic [31:0] addr;
    } in_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } ctl_t;

    typedef struct packed {
        in_t         i;
        logic        er;
        logic        eresp;
        logic        ereq;
        logic [31:0] ea;
    } vec_t;

    logic        HCLK, HRESETn;
    logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic [2:0]  HSIZES, HBURSTS;
    logic [3:0]  HPROTS;
    logic        HREADYOUTS, HRESPS;
    logic        grant, HREADYM, HRESPM;
    logic        req_port, sel_out;
    logic [31:0] HADDRO;
    logic [1:0]  HTRANSO;
    logic        HWRITEO, HMASTLOCKO;
    logic [2:0]  HSIZEO, HBURSTO;
    logic [3:0]  HPROTO;

    int n_cmp = 0;
    int n_bad = 0;

    ahbmtx_l2_in_stg #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .grant(grant), .HREADYM(HREADYM), .HRESPM(HRESPM),
        .req_port(req_port), .sel_out(sel_out),
        .HADDRO(HADDRO), .HTRANSO(HTRANSO), .HWRITEO(HWRITEO),
        .HSIZEO(HSIZEO), .HBURSTO(HBURSTO), .HPROTO(HPROTO),
        .HMASTLOCKO(HMASTLOCKO)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Model: at most one parked address phase, plus a flag saying this
    // port owns the slave's current data phase.
    ctl_t pq[$];
    bit   dph;

    function automatic ctl_t live(input in_t i);
        return '{i.addr, i.trans, i.write, i.size, i.burst, i.prot, i.lock};
    endfunction

    function automatic bit newt(input in_t i);
        return i.sel && i.trans[1] && i.rdy;
    endfunction

    function automatic ctl_t m_ctl(input in_t i);
        return (pq.size() != 0) ? pq[0] : live(i);
    endfunction

    function automatic bit m_rdy(input in_t i);
        if (dph) return i.hm;
        return pq.size() == 0;
    endfunction

    function automatic void m_update(input in_t i);
        bit   t;
        ctl_t c;
        t = i.grant && i.hm;
        c = m_ctl(i);
        if (newt(i) && !t) pq.push_back(live(i));
        else if (t && pq.size() != 0) void'(pq.pop_front());
        if (t && c.trans[1]) dph = 1'b1;
        else if (i.hm) dph = 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t i);
        HSELS = i.sel; HTRANSS = i.trans; HWRITES = i.write;
        HSIZES = i.size; HBURSTS = i.burst; HPROTS = i.prot;
        HMASTLOCKS = i.lock; HREADYS = i.rdy; grant = i.grant;
        HREADYM = i.hm; HRESPM = i.respm; HADDRS = i.addr;
    endtask

    task automatic model_check(input in_t i);
        ctl_t c;
        c = m_ctl(i);
        chk("m_rdy", 64'(HREADYOUTS), 64'(m_rdy(i)));
        chk("m_resp", 64'(HRESPS), 64'(dph && i.respm));
        chk("m_req", 64'(req_port), 64'((pq.size() != 0) || newt(i)));
        chk("m_sel", 64'(sel_out), 64'((pq.size() != 0) || (i.sel && i.rdy)));
        chk("m_ctl", 64'({HADDRO, HTRANSO, HWRITEO, HSIZEO, HBURSTO,
                          HPROTO, HMASTLOCKO}), 64'(c));
    endtask

    task automatic advance(input in_t i);
        @(posedge HCLK);
        m_update(i);
        @(negedge HCLK);
    endtask

    function automatic in_t mi(input logic s, input logic [1:0] t,
                               input logic r, input logic g, input logic h,
                               input logic e, input logic [31:0] a,
                               input logic w);
        in_t x;
        x = '{s, t, w, 3'd2, 3'd0, 4'h3, 1'b0, r, g, h, e, a};
        return x;
    endfunction

    vec_t tv[$];
    in_t  cur;

    initial begin
        HRESETn = 1'b0;
        pq.delete();
        dph = 1'b0;
        cur = mi(1, 2'd2, 1, 1, 1, 1, 32'h1234, 1);
        drive(cur);
        #2;
        chk("rst_rdy", 64'(HREADYOUTS), 64'd1);
        chk("rst_resp", 64'(HRESPS), 64'd0);
        chk("rst_req", 64'(req_port), 64'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        tv.push_back('{mi(0,0,1,0,1,0,32'h0,0),        1,0,0,32'h0});
        tv.push_back('{mi(1,2,1,1,1,0,32'h2000_0000,1), 1,0,1,32'h2000_0000});
        tv.push_back('{mi(0,0,1,0,1,0,32'h0,0),        1,0,0,32'h0});
        tv.push_back('{mi(1,2,1,0,1,0,32'h40,0),       1,0,1,32'h40});
        tv.push_back('{mi(1,2,0,0,1,0,32'h999,0),      0,0,1,32'h40});
        tv.push_back('{mi(1,2,0,0,1,0,32'h999,0),      0,0,1,32'h40});
        tv.push_back('{mi(1,2,0,0,1,0,32'h999,0),      0,0,1,32'h40});
        tv.push_back('{mi(1,2,0,1,1,0,32'h999,0),      0,0,1,32'h40});
        tv.push_back('{mi(0,0,0,0,0,0,32'h0,0),        0,0,0,32'h0});
        tv.push_back('{mi(0,0,0,0,0,0,32'h0,0),        0,0,0,32'h0});
        tv.push_back('{mi(0,0,0,0,1,0,32'h0,0),        1,0,0,32'h0});
        tv.push_back('{mi(1,2,1,1,1,0,32'h80,0),       1,0,1,32'h80});
        tv.push_back('{mi(0,0,0,0,0,1,32'h0,0),        0,1,0,32'h0});
        tv.push_back('{mi(0,0,0,0,1,1,32'h0,0),        1,1,0,32'h0});
        tv.push_back('{mi(1,2,1,1,1,0,32'h100,1),      1,0,1,32'h100});
        tv.push_back('{mi(1,2,1,0,1,0,32'h104,1),      1,0,1,32'h104});
        tv.push_back('{mi(1,2,0,0,0,1,32'h555,0),      0,0,1,32'h104});
        tv.push_back('{mi(1,2,0,1,1,0,32'h555,0),      0,0,1,32'h104});
        tv.push_back('{mi(0,0,0,0,1,0,32'h0,0),        1,0,0,32'h0});

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].i);
            #1;
            chk($sformatf("tv%0d_rdy", k), 64'(HREADYOUTS), 64'(tv[k].er));
            chk($sformatf("tv%0d_resp", k), 64'(HRESPS), 64'(tv[k].eresp));
            chk($sformatf("tv%0d_req", k), 64'(req_port), 64'(tv[k].ereq));
            chk($sformatf("tv%0d_addr", k), 64'(HADDRO), 64'(tv[k].ea));
            model_check(tv[k].i);
            advance(tv[k].i);
        end

        // Reset while both parked and owning a stalled data phase.
        cur = mi(1, 2, 1, 1, 1, 0, 32'h3000_0000, 1);
        drive(cur); #1; model_check(cur); advance(cur);
        cur = mi(1, 2, 1, 0, 0, 1, 32'h3000_0100, 0);
        drive(cur); #1; model_check(cur); advance(cur);
        drive(cur); #1;
        chk("pre_rst_rdy", 64'(HREADYOUTS), 64'd0);
        chk("pre_rst_resp", 64'(HRESPS), 64'd1);
        chk("pre_rst_req", 64'(req_port), 64'd1);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_rdy", 64'(HREADYOUTS), 64'd1);
        chk("mid_rst_resp", 64'(HRESPS), 64'd0);
        chk("mid_rst_req", 64'(req_port), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        pq.delete();
        dph = 1'b0;
        cur = mi(1, 2, 1, 1, 1, 0, 32'h3000_0200, 0);
        drive(cur); #1;
        chk("post_rst_req", 64'(req_port), 64'd1);
        chk("post_rst_addr", 64'(HADDRO), 64'h3000_0200);
        chk("post_rst_rdy", 64'(HREADYOUTS), 64'd1);
        model_check(cur);
        advance(cur);

        // Random traffic; the master sees its own HREADYOUTS as HREADYS.
        for (int k = 0; k < 400; k++) begin
            cur.sel   = 1'($urandom_range(0, 3) != 0);
            cur.trans = 2'($urandom);
            cur.write = 1'($urandom);
            cur.size  = 3'($urandom);
            cur.burst = 3'($urandom);
            cur.prot  = 4'($urandom);
            cur.lock  = 1'($urandom);
            cur.grant = 1'($urandom);
            cur.hm    = 1'($urandom_range(0, 3) != 0);
            cur.respm = 1'($urandom_range(0, 4) == 0);
            cur.addr  = $urandom;
            cur.rdy   = m_rdy(cur);
            drive(cur);
            #1;
            model_check(cur);
            advance(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
